// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit that owns the HI/LO registers.
// Signed operands are reduced to magnitudes at start and sign-corrected in the FIX cycle.
module muldiv_hilo_unit #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  state_t      state_r, state_nxt_s;
  logic [4:0]  cnt_r;
  logic [1:0]  op_r;
  logic        neg_res_r, neg_rem_r;
  logic [31:0] rs_orig_r, opnd_r, rem_r;
  logic [63:0] acc_r;
  logic [31:0] hi_r, lo_r;
  logic        busy_r, done_r, dbz_r;

  logic        accept_s, sgn_a_s, sgn_b_s, div0_s;
  logic [31:0] mag_a_s, mag_b_s, div_rem_s, quo_fix_s, rem_fix_s;
  logic [32:0] mul_sum_s, rem_sh_s, diff_s;
  logic [63:0] prod_fix_s;

  // Operand capture: signs only matter for MULT/DIV (op[0]=0).
  always_comb begin
    accept_s = (state_r == ST_IDLE) && start;
    sgn_a_s  = ~op[0] && rs[31];
    sgn_b_s  = ~op[0] && rt[31];
    mag_a_s  = sgn_a_s ? neg32(rs) : rs;
    mag_b_s  = sgn_b_s ? neg32(rt) : rt;
  end

  // One shift-add or restoring-subtract step, plus final sign correction.
  always_comb begin
    if (acc_r[0]) begin
      mul_sum_s = {1'b0, acc_r[63:32]} + {1'b0, opnd_r};
    end else begin
      mul_sum_s = {1'b0, acc_r[63:32]};
    end
    rem_sh_s   = {rem_r, acc_r[31]};
    diff_s     = rem_sh_s - {1'b0, opnd_r};
    div_rem_s  = diff_s[32] ? rem_sh_s[31:0] : diff_s[31:0];
    div0_s     = op_r[1] && (opnd_r == 32'd0);
    prod_fix_s = neg_res_r ? neg64(acc_r) : acc_r;
    quo_fix_s  = neg_res_r ? neg32(acc_r[31:0]) : acc_r[31:0];
    rem_fix_s  = neg_rem_r ? neg32(rem_r) : rem_r;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == 5'd31) begin
          state_nxt_s = ST_FIX;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FIX:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Iteration datapath; for divide acc_r[31:0] holds the dividend/quotient.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= 5'd0;
      op_r      <= 2'd0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      rs_orig_r <= 32'd0;
      opnd_r    <= 32'd0;
      rem_r     <= 32'd0;
      acc_r     <= 64'd0;
    end else if (accept_s) begin
      cnt_r     <= 5'd0;
      op_r      <= op;
      neg_res_r <= sgn_a_s ^ sgn_b_s;
      neg_rem_r <= sgn_a_s;
      rs_orig_r <= rs;
      rem_r     <= 32'd0;
      if (op[1]) begin
        acc_r  <= {32'd0, mag_a_s};
        opnd_r <= mag_b_s;
      end else begin
        acc_r  <= {32'd0, mag_b_s};
        opnd_r <= mag_a_s;
      end
    end else if (state_r == ST_RUN) begin
      cnt_r <= cnt_r + 5'd1;
      if (op_r[1]) begin
        acc_r <= {32'd0, acc_r[30:0], ~diff_s[32]};
        rem_r <= div_rem_s;
      end else begin
        acc_r <= {mul_sum_s, acc_r[31:1]};
      end
    end
  end

  // HI/LO: result at the FIX edge, MTHI/MTLO only when idle and not starting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (state_r == ST_FIX) begin
      if (div0_s) begin
        hi_r <= rs_orig_r;
        lo_r <= DIV0_QUOT;
      end else if (op_r[1]) begin
        hi_r <= rem_fix_s;
        lo_r <= quo_fix_s;
      end else begin
        hi_r <= prod_fix_s[63:32];
        lo_r <= prod_fix_s[31:0];
      end
    end else if ((state_r == ST_IDLE) && !start) begin
      if (mthi) begin
        hi_r <= wdata;
      end
      if (mtlo) begin
        lo_r <= wdata;
      end
    end
  end

  // Registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != ST_IDLE);
      done_r <= (state_r == ST_FIX);
      dbz_r  <= (state_r == ST_FIX) && div0_s;
    end
  end

  assign hi          = hi_r;
  assign lo          = lo_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit: directed cases plus random ops
// checked against an arithmetic reference model.
module tb_muldiv_hilo_unit;

  logic        clk = 1'b0;
  logic        rst, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] rs, rt, wdata, hi, lo;
  logic        busy, done, div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a, b, h, l;
    logic        z;
  } vec_t;

  muldiv_hilo_unit #(.WIDTH(32), .DIV0_QUOT(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs(rs), .rt(rt),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: {div_by_zero, hi, lo} from plain 64-bit arithmetic.
  function automatic logic [64:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin q = sa * sb; return {1'b0, q}; end
      2'b01: begin up = {32'd0, a} * {32'd0, b}; return {1'b0, up}; end
      2'b10: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  // Issue one op (caller sits at a negedge) and wait for busy to fall.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int cyc, output logic d, output logic z,
                       output logic held, output logic d_next);
    logic [31:0] old_hi, old_lo;
    old_hi = hi;
    old_lo = lo;
    op = o; rs = a; rt = b; start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    d_next = done;
    cyc    = 0;
    held   = 1'b1;
    while (busy && cyc < 100) begin
      cyc++;
      if (hi !== old_hi || lo !== old_lo) held = 1'b0;
      @(negedge clk);
    end
    d = done;
    z = div_by_zero;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'd0; rs = 32'd0; rt = 32'd0; wdata = 32'd0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
    checks++; if ({busy, done, div_by_zero} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, div_by_zero});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    vec_t vecs [5];
    int   cyc;
    logic d, z, held, dn;
    vecs[0] = '{2'b00, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[4] = '{2'b11, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
    for (int i = 0; i < 5; i++) begin
      do_op(vecs[i].o, vecs[i].a, vecs[i].b, cyc, d, z, held, dn);
      checks++; if (cyc != 33) begin errors++; $display("FAIL dir_busy[%0d]: got %0d cycles expected 33", i, cyc); end
      checks++; if (d !== 1'b1) begin errors++; $display("FAIL dir_done[%0d]: got %b expected 1", i, d); end
      checks++; if (hi !== vecs[i].h) begin errors++; $display("FAIL dir_hi[%0d]: got %h expected %h", i, hi, vecs[i].h); end
      checks++; if (lo !== vecs[i].l) begin errors++; $display("FAIL dir_lo[%0d]: got %h expected %h", i, lo, vecs[i].l); end
      checks++; if (z !== vecs[i].z) begin errors++; $display("FAIL dir_dbz[%0d]: got %b expected %b", i, z, vecs[i].z); end
      checks++; if (held !== 1'b1) begin errors++; $display("FAIL dir_hold[%0d]: hi/lo changed while busy", i); end
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] old_lo;
    int          cyc;
    logic        d, z, held, dn;
    old_lo = lo;
    wdata = 32'hA5A5_A5A5; mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    checks++; if (hi !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mthi: got %h expected a5a5a5a5", hi); end
    checks++; if (lo !== old_lo) begin errors++; $display("FAIL mthi_lo_kept: got %h expected %h", lo, old_lo); end
    wdata = 32'h5A5A_5A5A; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    checks++; if ({hi, lo} !== {2{32'h5A5A_5A5A}}) begin
      errors++; $display("FAIL mthi_mtlo_both: got %h %h expected 5a5a5a5a 5a5a5a5a", hi, lo);
    end
    // start wins over a simultaneous MTHI/MTLO, which then stay asserted while busy
    wdata = 32'hDEAD_BEEF; mthi = 1'b1; mtlo = 1'b1;
    do_op(2'b01, 32'd7, 32'd6, cyc, d, z, held, dn);
    mthi = 1'b0; mtlo = 1'b0;
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL start_wins_hold: hi/lo written during op"); end
    checks++; if ({hi, lo} !== {32'd0, 32'd42}) begin
      errors++; $display("FAIL start_wins_result: got %h %h expected 00000000 0000002a", hi, lo);
    end
  endtask

  task automatic test_ignore_busy();
    int cyc;
    wdata = 32'hA5A5_A5A5; mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    checks++; if (hi !== 32'hA5A5_A5A5) begin errors++; $display("FAIL ign_mthi: got %h expected a5a5a5a5", hi); end
    op = 2'b01; rs = 32'd2; rt = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      if (cyc == 10) begin
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; op = 2'b10;
        rs = $urandom; rt = $urandom; wdata = 32'h1357_9BDF;
      end else begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      if (cyc == 20) begin
        checks++; if (hi !== 32'hA5A5_A5A5) begin errors++; $display("FAIL ign_mid_hi: got %h expected a5a5a5a5", hi); end
      end
      @(negedge clk);
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    checks++; if (cyc != 33) begin errors++; $display("FAIL ign_busy_len: got %0d expected 33", cyc); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ign_done: got %b expected 1", done); end
    checks++; if ({hi, lo} !== {32'd0, 32'd6}) begin
      errors++; $display("FAIL ign_result: got %h %h expected 00000000 00000006", hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    logic saw;
    wdata = 32'h0F0F_0F0F; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    op = 2'b01; rs = 32'd2; rt = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL rstmid_hilo: got %h %h expected 0 0", hi, lo); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rstmid_flags: got %b expected 00", {busy, done}); end
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy || div_by_zero) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL rstmid_no_done: got activity expected none"); end
    checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL rstmid_after: got %h %h expected 0 0", hi, lo); end
  endtask

  task automatic test_back_to_back();
    int   cyc;
    logic d, z, held, dn;
    do_op(2'b11, 32'd100, 32'd7, cyc, d, z, held, dn);
    checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL b2b_divu: got %h %h expected 2 e", hi, lo); end
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, d, z, held, dn);
    checks++; if (dn !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse: got %b expected 0", dn); end
    checks++; if (cyc != 33) begin errors++; $display("FAIL b2b_busy: got %0d expected 33", cyc); end
    checks++; if ({hi, lo} !== {32'd0, 32'd1}) begin errors++; $display("FAIL b2b_mult: got %h %h expected 0 1", hi, lo); end
  endtask

  task automatic test_random();
    int          cyc, sel;
    logic        d, z, held, dn;
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [64:0] exp_v;
    for (int i = 0; i < 40; i++) begin
      o   = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) b = 32'($urandom_range(1, 9));
      else if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 3) a = 32'($urandom_range(0, 999));
      exp_v = ref_op(o, a, b);
      do_op(o, a, b, cyc, d, z, held, dn);
      checks++; if (cyc != 33 || d !== 1'b1 || dn !== 1'b0) begin
        errors++; $display("FAIL rnd_timing[%0d]: got cycles=%0d done=%b done_after_start=%b expected 33 1 0", i, cyc, d, dn);
      end
      checks++; if ({hi, lo} !== exp_v[63:0]) begin
        errors++; $display("FAIL rnd_hilo[%0d] op=%0d rs=%h rt=%h: got %h %h expected %h %h", i, o, a, b, hi, lo, exp_v[63:32], exp_v[31:0]);
      end
      checks++; if (z !== exp_v[64]) begin
        errors++; $display("FAIL rnd_dbz[%0d] op=%0d rt=%h: got %b expected %b", i, o, b, z, exp_v[64]);
      end
      checks++; if (held !== 1'b1) begin errors++; $display("FAIL rnd_hold[%0d]: hi/lo changed while busy", i); end
    end
    @(negedge clk);
    checks++; if ({done, div_by_zero} !== 2'b00) begin
      errors++; $display("FAIL rnd_pulse_end: got %b expected 00", {done, div_by_zero});
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mthi_mtlo();
    test_ignore_busy();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
